mem_datos_access_unit: RTL and testbench

//  Parametrised, registered load/store front-end for the MIPS data memory. Accepts one request
//  per handshake. Generates column (byte) write enables and lane-replicated write data. Waits a

---
 rtl/mem_datos_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_datos_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_datos_access_unit.sv
// rtl/mem_datos_access_unit.sv - registered load/store front-end for the MIPS data memory
// Issues column-enabled stores, waits the BRAM read latency for loads, extends the addressed lane.
module mem_datos_access_unit #(
  parameter int CANT_BITS_DATA                  = 32,
  parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int CANT_BITS_ADDR                  = 11,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  parameter int READ_LATENCY                    = 1
) (
  input  logic                                                          i_clock,
  input  logic                                                          i_reset,
  input  logic                                                          i_valid,
  output logic                                                          o_ready,
  input  logic                                                          i_read_mem,
  input  logic                                                          i_write_mem,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0]                    i_select_bytes_mem_datos,
  input  logic [CANT_BITS_ADDR-1:0]                                     i_address,
  input  logic [CANT_BITS_DATA-1:0]                                     i_write_data,
  output logic [CANT_BITS_ADDR-$clog2(CANT_COLUMNAS_MEM_DATOS)-1:0]     o_mem_address,
  output logic                                                          o_mem_enable,
  output logic [CANT_COLUMNAS_MEM_DATOS-1:0]                            o_mem_write_enable,
  output logic [CANT_BITS_DATA-1:0]                                     o_mem_write_data,
  input  logic [CANT_BITS_DATA-1:0]                                     i_mem_read_data,
  output logic [CANT_BITS_DATA-1:0]                                     o_read_data,
  output logic                                                          o_read_valid,
  output logic                                                          o_misaligned
);

  localparam int COLS  = CANT_COLUMNAS_MEM_DATOS;
  localparam int LOG   = $clog2(COLS);
  localparam int HCOLS = COLS / 2;
  localparam int DATA  = CANT_BITS_DATA;
  localparam int HALF  = DATA / 2;
  localparam int ADDR  = CANT_BITS_ADDR;
  localparam logic [LOG-1:0] HALF_MASK = LOG'(HCOLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [DATA-1:0]   wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              write_q, write_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA-1:0]   rdata_q, rdata_d;

  logic              misaligned_in;
  logic [7:0]        load_byte;
  logic [HALF-1:0]   load_half;
  logic [DATA-1:0]   load_ext;
  logic [COLS-1:0]   store_we;
  logic [DATA-1:0]   store_wdata;

  always_comb begin
    misaligned_in = 1'b0;
    case (i_select_bytes_mem_datos[1:0])
      2'd2:    misaligned_in = (i_address[LOG-1:0] & HALF_MASK) != '0;
      2'd3:    misaligned_in = i_address[LOG-1:0] != '0;
      default: misaligned_in = 1'b0;
    endcase
  end

  // Lane extraction works on the live BRAM word; only the last WAIT cycle latches it.
  assign load_byte = i_mem_read_data[{addr_q[LOG-1:0], 3'b000} +: 8];
  assign load_half = addr_q[LOG-1] ? i_mem_read_data[DATA-1:HALF] : i_mem_read_data[HALF-1:0];

  always_comb begin
    load_ext = i_mem_read_data;
    case (size_q)
      2'd1: load_ext = unsigned_q ? {{(DATA-8){1'b0}}, load_byte}
                                  : {{(DATA-8){load_byte[7]}}, load_byte};
      2'd2: load_ext = unsigned_q ? {{(DATA-HALF){1'b0}}, load_half}
                                  : {{(DATA-HALF){load_half[HALF-1]}}, load_half};
      default: load_ext = i_mem_read_data;
    endcase
  end

  always_comb begin
    store_we    = '1;
    store_wdata = wdata_q;
    case (size_q)
      2'd1: begin
        store_we    = {{(COLS-1){1'b0}}, 1'b1} << addr_q[LOG-1:0];
        store_wdata = {COLS{wdata_q[7:0]}};
      end
      2'd2: begin
        store_we    = {{HCOLS{addr_q[LOG-1]}}, {HCOLS{~addr_q[LOG-1]}}};
        store_wdata = {2{wdata_q[HALF-1:0]}};
      end
      default: begin
        store_we    = '1;
        store_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    size_d             = size_q;
    unsigned_d         = unsigned_q;
    write_d            = write_q;
    cnt_d              = cnt_q;
    rdata_d            = rdata_q;
    o_ready            = 1'b0;
    o_mem_enable       = 1'b0;
    o_mem_address      = '0;
    o_mem_write_enable = '0;
    o_mem_write_data   = '0;
    o_read_valid       = 1'b0;
    o_misaligned       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        // Load wins when both ops are raised; size 0 or no op is a silent no-op.
        if (i_valid && (i_read_mem || i_write_mem) && (i_select_bytes_mem_datos[1:0] != 2'd0)) begin
          addr_d     = i_address;
          wdata_d    = i_write_data;
          size_d     = i_select_bytes_mem_datos[1:0];
          unsigned_d = i_select_bytes_mem_datos[2];
          write_d    = ~i_read_mem;
          state_d    = misaligned_in ? ST_ERROR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_mem_enable  = 1'b1;
        o_mem_address = addr_q[ADDR-1:LOG];
        if (write_q) begin
          o_mem_write_enable = store_we;
          o_mem_write_data   = store_wdata;
          state_d            = ST_IDLE;
        end else begin
          cnt_d   = 3'(READ_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = load_ext;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        o_read_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_ERROR: begin
        o_misaligned = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_read_data = rdata_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      cnt_q      <= 3'd0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_datos_access_unit.sv
// tb/tb_mem_datos_access_unit.sv - self-checking bench for mem_datos_access_unit
module tb_mem_datos_access_unit;
  localparam int RL = 1;
  localparam int K_NONE = 0, K_STORE = 1, K_LOAD = 2, K_ERR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_valid, i_read_mem, i_write_mem;
  logic [2:0]  sel;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic        o_ready, o_mem_enable, o_read_valid, o_misaligned;
  logic [8:0]  o_mem_address;
  logic [3:0]  o_we;
  logic [31:0] o_wd, mem_rd, o_read_data;

  logic        v2, o_ready2, en2, rv2, mis2;
  logic [8:0]  maddr2;
  logic [3:0]  we2;
  logic [31:0] wd2, rd2;

  int total = 0;
  int bad = 0;

  mem_datos_access_unit #(.READ_LATENCY(RL)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_read_mem(i_read_mem), .i_write_mem(i_write_mem), .i_select_bytes_mem_datos(sel),
    .i_address(addr), .i_write_data(wdata), .o_mem_address(o_mem_address),
    .o_mem_enable(o_mem_enable), .o_mem_write_enable(o_we), .o_mem_write_data(o_wd),
    .i_mem_read_data(mem_rd), .o_read_data(o_read_data), .o_read_valid(o_read_valid),
    .o_misaligned(o_misaligned)
  );

  mem_datos_access_unit #(.READ_LATENCY(3)) dut3 (
    .i_clock(clk), .i_reset(i_reset), .i_valid(v2), .o_ready(o_ready2),
    .i_read_mem(1'b1), .i_write_mem(1'b0), .i_select_bytes_mem_datos(3'b011),
    .i_address(11'h010), .i_write_data(32'h0), .o_mem_address(maddr2),
    .o_mem_enable(en2), .o_mem_write_enable(we2), .o_mem_write_data(wd2),
    .i_mem_read_data(32'hCAFEF00D), .o_read_data(rd2), .o_read_valid(rv2),
    .o_misaligned(mis2)
  );

  function automatic logic [31:0] init_word(input int w);
    if (w == 0) return 32'h8001_80FF;
    if (w == 1) return 32'h1122_3344;
    return 32'h5A00_0000 | 32'(w * 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM stand-in driven by the DUT's memory port
  logic [31:0] bram [0:511];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < 512; w++) bram[w] <= init_word(w);
    end else if (o_mem_enable) begin
      for (int b = 0; b < 4; b++)
        if (o_we[b]) bram[o_mem_address][b*8 +: 8] <= o_wd[b*8 +: 8];
      mem_rd <= bram[o_mem_address];
    end
  end

  // Behavioural model: byte-addressed shadow memory plus cycle offset since acceptance
  logic [7:0] shadow [0:2047];
  initial begin : model
    int k, kind, busy_len, nbytes, a, lo;
    logic known, act, rd, wr;
    logic [10:0] m_addr;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [31:0] m_wdata, m_rdata, v, e_wd;
    logic [3:0]  e_we;
    for (int w = 0; w < 512; w++) begin
      v = init_word(w);
      for (int b = 0; b < 4; b++) shadow[w*4+b] = v[b*8 +: 8];
    end
    known = 0; kind = K_NONE; k = 0; m_rdata = 0;
    m_addr = 0; m_size = 0; m_uns = 0; m_wdata = 0;
    forever begin
      @(negedge clk);
      busy_len = (kind == K_LOAD) ? 2 + RL : 1;
      act = (kind != K_NONE) && (k >= 1) && (k <= busy_len);
      nbytes = (m_size == 2'd1) ? 1 : (m_size == 2'd2) ? 2 : 4;
      a = int'(m_addr);
      lo = a % 4;
      if (known) begin
        e_we = 0; e_wd = 0;
        if (kind == K_STORE && k == 1) begin
          for (int i = 0; i < 4; i++) begin
            e_wd[i*8 +: 8] = m_wdata[(i % nbytes)*8 +: 8];
            if (i >= lo && i < lo + nbytes) begin
              e_we[i] = 1'b1;
              shadow[a - lo + i] = e_wd[i*8 +: 8];
            end
          end
        end
        if (kind == K_LOAD && k == 2 + RL) begin
          v = 0;
          for (int j = 0; j < nbytes; j++) v = v | (32'(shadow[a + j]) << (8*j));
          if (!m_uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
          m_rdata = v;
        end
        chk("ready", 32'(o_ready), 32'(!act));
        chk("mem_enable", 32'(o_mem_enable), 32'(act && k == 1 && kind != K_ERR));
        chk("write_enable", 32'(o_we), 32'(e_we));
        chk("misaligned", 32'(o_misaligned), 32'(kind == K_ERR && k == 1));
        chk("read_valid", 32'(o_read_valid), 32'(kind == K_LOAD && k == 2 + RL));
        chk("read_data", o_read_data, m_rdata);
        if (act && k == 1 && kind != K_ERR) chk("mem_address", 32'(o_mem_address), 32'(m_addr[10:2]));
        if (kind == K_STORE && k == 1) chk("write_data", o_wd, e_wd);
      end
      if (i_reset) begin
        known = 1; kind = K_NONE; k = 0; m_rdata = 0;
      end else if (!act && i_valid) begin
        rd = i_read_mem;
        wr = i_write_mem && !rd;
        if (sel[1:0] != 2'd0 && (rd || wr)) begin
          m_addr = addr; m_size = sel[1:0]; m_uns = sel[2]; m_wdata = wdata; k = 1;
          if ((sel[1:0] == 2'd2 && addr % 2 != 0) || (sel[1:0] == 2'd3 && addr % 4 != 0)) kind = K_ERR;
          else kind = rd ? K_LOAD : K_STORE;
        end
      end else if (act) begin
        k++;
        if (k > busy_len) begin kind = K_NONE; k = 0; end
      end
    end
  end

  logic        c1_en, c1_mis, c1_ready, c2_ready, c3_rv;
  logic [8:0]  c1_addr;
  logic [3:0]  c1_we;
  logic [31:0] c1_wd, c3_rd;

  task automatic issue(input logic rdm, input logic wrm, input logic [2:0] s,
                       input logic [10:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    i_valid = 1; i_read_mem = rdm; i_write_mem = wrm; sel = s; addr = a; wdata = d;
    @(posedge clk); #1;
    i_valid = 0; i_read_mem = 0; i_write_mem = 0;
    c1_en = o_mem_enable; c1_mis = o_misaligned; c1_ready = o_ready;
    c1_addr = o_mem_address; c1_we = o_we; c1_wd = o_wd;
    @(posedge clk); #1;
    c2_ready = o_ready;
    @(posedge clk); #1;
    c3_rv = o_read_valid; c3_rd = o_read_data;
  endtask

  typedef struct {
    logic [2:0]  s;
    logic [10:0] a;
    logic [31:0] e;
  } ld_t;
  ld_t lds [8];

  initial begin
    logic [12:0] rdy_bits, rv_bits;
    logic [31:0] d5;
    logic [8:0]  a1;
    lds[0] = '{3'b001, 11'h001, 32'hFFFF_FF80};
    lds[1] = '{3'b101, 11'h001, 32'h0000_0080};
    lds[2] = '{3'b010, 11'h002, 32'hFFFF_8001};
    lds[3] = '{3'b110, 11'h002, 32'h0000_8001};
    lds[4] = '{3'b011, 11'h004, 32'h1234_3344};
    lds[5] = '{3'b011, 11'h008, 32'hDEAD_BEEF};
    lds[6] = '{3'b001, 11'h000, 32'hFFFF_FFFF};
    lds[7] = '{3'b101, 11'h003, 32'h0000_0080};
    i_reset = 1; i_valid = 0; i_read_mem = 0; i_write_mem = 0;
    sel = 0; addr = 0; wdata = 0; v2 = 0; init_mem = 1;
    repeat (3) @(posedge clk);
    #1; i_reset = 0; init_mem = 0;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_enable", 32'(o_mem_enable), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_rvalid", 32'(o_read_valid), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_rdata", o_read_data, 32'd0);

    issue(0, 1, 3'b011, 11'h008, 32'hDEAD_BEEF);
    chk("sw_we", 32'(c1_we), 32'hF);
    chk("sw_addr", 32'(c1_addr), 32'd2);
    chk("sw_wdata", c1_wd, 32'hDEAD_BEEF);
    chk("sw_busy_c1", 32'(c1_ready), 32'd0);
    chk("sw_ready_c2", 32'(c2_ready), 32'd1);
    issue(0, 1, 3'b001, 11'h007, 32'h0000_00A5);
    chk("sb_we", 32'(c1_we), 32'h8);
    chk("sb_wdata", c1_wd, 32'hA5A5_A5A5);
    issue(0, 1, 3'b010, 11'h006, 32'h0000_1234);
    chk("sh_we", 32'(c1_we), 32'hC);
    chk("sh_wdata", c1_wd, 32'h1234_1234);
    issue(0, 1, 3'b010, 11'h005, 32'h0000_FFFF);
    chk("sh_mis_flag", 32'(c1_mis), 32'd1);
    chk("sh_mis_en", 32'(c1_en), 32'd0);
    chk("sh_mis_we", 32'(c1_we), 32'd0);
    issue(0, 1, 3'b011, 11'h002, 32'hFFFF_FFFF);
    chk("sw_mis_flag", 32'(c1_mis), 32'd1);
    chk("sw_mis_en", 32'(c1_en), 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(1, 0, lds[i].s, lds[i].a, 32'h0);
      chk($sformatf("load%0d_valid_c3", i), 32'(c3_rv), 32'd1);
      chk($sformatf("load%0d_data", i), c3_rd, lds[i].e);
    end

    issue(1, 1, 3'b011, 11'h008, 32'h0000_0000);
    chk("rw_we", 32'(c1_we), 32'd0);
    chk("rw_load", c3_rd, 32'hDEAD_BEEF);
    issue(1, 0, 3'b011, 11'h008, 32'h0);
    chk("rw_no_write", c3_rd, 32'hDEAD_BEEF);

    issue(1, 0, 3'b000, 11'h004, 32'h0);
    chk("noop_ready", 32'(c1_ready), 32'd1);
    chk("noop_en", 32'(c1_en), 32'd0);

    @(posedge clk); #1;
    i_valid = 1; i_read_mem = 1; sel = 3'b011; addr = 11'h008;
    @(posedge clk); #1;
    i_valid = 0; i_read_mem = 0;
    @(posedge clk); #1;
    i_reset = 1;
    @(posedge clk); #1;
    i_reset = 0;
    chk("rstwait_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rstwait_rvalid", 32'(o_read_valid), 32'd0);
      chk("rstwait_rdata", o_read_data, 32'd0);
      @(posedge clk); #1;
    end

    @(posedge clk); #1;
    v2 = 1; rdy_bits = 0; rv_bits = 0; d5 = 0; a1 = 0;
    rdy_bits[0] = o_ready2; rv_bits[0] = rv2;
    for (int c = 1; c < 13; c++) begin
      @(posedge clk); #1;
      if (c == 12) v2 = 0;
      rdy_bits[c] = o_ready2;
      rv_bits[c] = rv2;
      if (c == 1) a1 = maddr2;
      if (c == 5) d5 = rd2;
    end
    chk("rl3_ready_pattern", 32'(rdy_bits), 32'h1041);
    chk("rl3_rvalid_pattern", 32'(rv_bits), 32'h0820);
    chk("rl3_mem_addr", 32'(a1), 32'd4);
    chk("rl3_data", d5, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
